sr_addsub_arb: RTL and testbench
================================

# sr_addsub_arb

Shared add/sub execution unit with an N-channel arbiter, pipelined. It replaces the single-cycle priority-encoder/mux/decoder sharing scheme inside the ALU's multicycle path. Parametrised channel count and operand width; round-robin or fixed-priority selection. Registered grant and result stages sustain one operation per cycle across channels. Clients (cubic root, square root, final-sum sequencer and future multicycle units) each own one channel and use a req/ack handshake.

## Interface
- N_CH, 4, number of client channels (2..16)
- WIDTH, 8, operand/result width in bits (4..32)
- RR, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins)

- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  reset, synchronous, active-high
- req_i  input  N_CH  per-channel request; operands and mode must be stable while high
- mode_i  input  N_CH  per-channel op: 1 = a+b, 0 = a-b
- a_i  input  N_CH*WIDTH  channel k operand A at [k*WIDTH +: WIDTH]
- b_i  input  N_CH*WIDTH  channel k operand B at [k*WIDTH +: WIDTH]
- gnt_o  output  N_CH  one-hot registered grant; high for exactly one cycle
- ack_o  output  N_CH  one-hot registered result-valid strobe; high for exactly one cycle
- res_o  output  WIDTH  result; valid while any ack_o bit is high
- carry_o  output  1  add: carry-out; sub: borrow (a < b unsigned); valid with ack
- zero_o  output  1  res_o == 0; valid with ack
- busy_o  output  1  grant stage or result stage occupied

## Operation
- Eligibility: channel k eligible iff req_i[k] & ~gnt_o[k] & ~ack_o[k]. A channel's request is ignored while its own operation is in flight.
- Arbitration (combinational, sampled at each edge):
  - RR=1: search eligible channels starting at index ptr, ascending, wrapping N_CH-1 -> 0. After a grant to channel k, ptr <= (k+1) mod N_CH. ptr holds when nothing is granted.
  - RR=0: lowest eligible index wins; ptr unused.
- Stage 1 (grant) captures the winner's a, b, mode and index. It also sets gnt_o[winner]. If no channel is eligible, the stage is empty.
- Stage 2 (result) computes at WIDTH+1 bits: add = {0,a}+{0,b}; sub = {0,a}-{0,b}.
  - res_o = low WIDTH bits; carry_o = bit WIDTH. For sub, bit WIDTH is the borrow.
  - Modular wrap-around at WIDTH bits; no saturation.
- res_o, carry_o and zero_o hold their last values when ack_o = 0. The bench checks them only during ack.
- busy_o = stage1 valid | stage2 valid.
- Reset: gnt_o=0, ack_o=0, res_o=0, carry_o=0, zero_o=0 (stage2 defaults), busy_o=0, ptr=0.
  - Reset mid-operation drops in-flight operations silently; no ack is issued for them.
  - Clients must also be reset.

## Timing
- Edge E0: req_i[k] sampled eligible and wins. Cycle C1: gnt_o[k]=1.
- Edge E1: result registered. Cycle C2: ack_o[k]=1, res_o valid.
- Latency from request sampled to ack is 2 cycles.
- Client drops or updates req/operands at E2. Earliest re-grant of the same channel is at E3, so one channel issues at most one op per 3 cycles.
- Different channels pipeline back-to-back: up to one grant and one ack per cycle.
- Simultaneous requests: exactly one grant per cycle. Losers keep req high and are re-evaluated next edge. Round-robin bounds the wait to N_CH-1 grants.
- req_i deasserted before grant: the request is withdrawn and no operation occurs. Deasserting after grant has no effect; the ack still arrives.

## Test plan
- Reset then idle: rst_i high 2 cycles, req_i=0 for 10 cycles -> gnt_o, ack_o, busy_o stay 0; res_o=0.
- Single add, WIDTH=8: ch1 a=200, b=100, mode=1 at E0 -> gnt_o=0010 in C1; ack_o=0010 in C2 with res_o=44, carry_o=1, zero_o=0.
- Subtract boundary: ch0 a=5, b=5, mode=0 -> res_o=0, zero_o=1, carry_o=0. Then a=3, b=4 -> res_o=255, carry_o=1.
- Round-robin contention, RR=1, N_CH=4: all four reqs held continuously from reset; each client drops req the cycle after its ack and re-raises 1 cycle later -> grant order 0,1,2,3,0,...; no channel gets two grants without all other requesters granted in between.
- Fixed priority, RR=0: ch0 and ch2 request together -> ch0 granted first and ch2 the next cycle; acks in the same order on consecutive cycles; busy_o high 3 cycles.
- Reset mid-flight: ch3 granted (gnt_o=1000), rst_i high the next cycle -> no ack_o for ch3, all outputs 0; the first grant after reset goes to the lowest eligible channel (ptr=0).

Source files
------------

// File: rtl/sr_addsub_arb_if.sv
// Client-side bundle for the shared add/sub unit.
// The client drives the requests and operands; the unit drives grant, ack and result.
interface sr_addsub_arb_if #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8
);
    logic [N_CH-1:0]       req_i;
    logic [N_CH-1:0]       mode_i;
    logic [N_CH*WIDTH-1:0] a_i;
    logic [N_CH*WIDTH-1:0] b_i;
    logic [N_CH-1:0]       gnt_o;
    logic [N_CH-1:0]       ack_o;
    logic [WIDTH-1:0]      res_o;
    logic                  carry_o;
    logic                  zero_o;
    logic                  busy_o;

    modport master (
        output req_i, mode_i, a_i, b_i,
        input  gnt_o, ack_o, res_o,
        input  carry_o, zero_o, busy_o
    );

    modport slave (
        input  req_i, mode_i, a_i, b_i,
        output gnt_o, ack_o, res_o,
        output carry_o, zero_o, busy_o
    );
endinterface

// File: rtl/sr_addsub_arb.sv
// Shared add/sub unit: the arbiter feeds a registered grant stage,
// which feeds a registered result stage (one op per cycle).
module sr_addsub_arb #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    parameter bit RR    = 1'b1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    sr_addsub_arb_if.slave bus
);
    localparam int IW = $clog2(N_CH);
    localparam int CW = IW + 1;
    typedef logic [IW-1:0] idx_t;

    logic [N_CH-1:0]  elig;
    logic [N_CH-1:0]  gnt_q, gnt_d;
    logic [N_CH-1:0]  ack_q;
    idx_t             ptr_q, ptr_d;
    idx_t             base;
    idx_t             win_idx;
    logic             win_vld;
    logic [CW-1:0]    cand;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic [WIDTH:0]   sum;

    // In-flight channels sit out until their ack has been seen.
    assign elig = bus.req_i & ~gnt_q & ~ack_q;
    assign base = RR ? ptr_q : '0;

    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 0; i < N_CH; i++) begin
            cand = {1'b0, base} + CW'(i);
            if (cand >= CW'(N_CH)) begin
                cand = cand - CW'(N_CH);
            end
            if (!win_vld && elig[cand[IW-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        gnt_d  = '0;
        ptr_d  = ptr_q;
        a_d    = a_q;
        b_d    = b_q;
        mode_d = mode_q;
        if (win_vld) begin
            gnt_d[win_idx] = 1'b1;
            if (win_idx == idx_t'(N_CH - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = win_idx + 1'b1;
            end
            a_d    = bus.a_i[win_idx*WIDTH +: WIDTH];
            b_d    = bus.b_i[win_idx*WIDTH +: WIDTH];
            mode_d = bus.mode_i[win_idx];
        end
    end

    assign sum = mode_q ? ({1'b0, a_q} + {1'b0, b_q})
                        : ({1'b0, a_q} - {1'b0, b_q});

    always_comb begin
        res_d   = res_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        if (|gnt_q) begin
            res_d   = sum[WIDTH-1:0];
            carry_d = sum[WIDTH];
            zero_d  = (sum[WIDTH-1:0] == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gnt_q   <= '0;
            ack_q   <= '0;
            ptr_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= 1'b0;
            res_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            gnt_q   <= gnt_d;
            ack_q   <= gnt_q;
            ptr_q   <= ptr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.gnt_o   = gnt_q;
    assign bus.ack_o   = ack_q;
    assign bus.res_o   = res_q;
    assign bus.carry_o = carry_q;
    assign bus.zero_o  = zero_q;
    assign bus.busy_o  = (|gnt_q) | (|ack_q);
endmodule

// File: tb/tb_sr_addsub_arb.sv
// Directed bench: one round-robin and one fixed-priority instance,
// four channels of eight bits each.
module tb_sr_addsub_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sr_addsub_arb_if #(.N_CH(4), .WIDTH(8)) if0 ();
    sr_addsub_arb_if #(.N_CH(4), .WIDTH(8)) if1 ();

    sr_addsub_arb #(.N_CH(4), .WIDTH(8), .RR(1'b1)) u_rr (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if0.slave)
    );

    sr_addsub_arb #(.N_CH(4), .WIDTH(8), .RR(1'b0)) u_fp (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if1.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (if0.gnt_o !== 4'b0000) begin
                n_err++;
                $display("FAIL idle_gnt: got %b want 0000", if0.gnt_o);
            end
            n_cmp++;
            if (if0.ack_o !== 4'b0000) begin
                n_err++;
                $display("FAIL idle_ack: got %b want 0000", if0.ack_o);
            end
            n_cmp++;
            if (if0.busy_o !== 1'b0) begin
                n_err++;
                $display("FAIL idle_busy: got %b want 0", if0.busy_o);
            end
            n_cmp++;
            if (if0.res_o !== 8'd0) begin
                n_err++;
                $display("FAIL idle_res: got %0d want 0", if0.res_o);
            end
            n_cmp++;
            if (if1.busy_o !== 1'b0) begin
                n_err++;
                $display("FAIL idle_busy_fp: got %b want 0", if1.busy_o);
            end
        end
    endtask

    task automatic test_single_add();
        if0.a_i[8 +: 8] = 8'd200;
        if0.b_i[8 +: 8] = 8'd100;
        if0.mode_i[1]   = 1'b1;
        if0.req_i[1]    = 1'b1;
        tick();
        n_cmp++;
        if (if0.gnt_o !== 4'b0010) begin
            n_err++;
            $display("FAIL add_gnt: got %b want 0010", if0.gnt_o);
        end
        n_cmp++;
        if (if0.busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL add_busy: got %b want 1", if0.busy_o);
        end
        tick();
        n_cmp++;
        if (if0.ack_o !== 4'b0010) begin
            n_err++;
            $display("FAIL add_ack: got %b want 0010", if0.ack_o);
        end
        n_cmp++;
        if (if0.gnt_o !== 4'b0000) begin
            n_err++;
            $display("FAIL add_nogrant: got %b want 0000", if0.gnt_o);
        end
        n_cmp++;
        if (if0.res_o !== 8'd44) begin
            n_err++;
            $display("FAIL add_res: got %0d want 44", if0.res_o);
        end
        n_cmp++;
        if (if0.carry_o !== 1'b1) begin
            n_err++;
            $display("FAIL add_carry: got %b want 1", if0.carry_o);
        end
        n_cmp++;
        if (if0.zero_o !== 1'b0) begin
            n_err++;
            $display("FAIL add_zero: got %b want 0", if0.zero_o);
        end
        if0.req_i[1] = 1'b0;
        tick();
    endtask

    task automatic test_sub();
        if0.a_i[0 +: 8] = 8'd5;
        if0.b_i[0 +: 8] = 8'd5;
        if0.mode_i[0]   = 1'b0;
        if0.req_i[0]    = 1'b1;
        tick();
        n_cmp++;
        if (if0.gnt_o !== 4'b0001) begin
            n_err++;
            $display("FAIL sub0_gnt: got %b want 0001", if0.gnt_o);
        end
        tick();
        n_cmp++;
        if (if0.ack_o !== 4'b0001) begin
            n_err++;
            $display("FAIL sub0_ack: got %b want 0001", if0.ack_o);
        end
        n_cmp++;
        if (if0.res_o !== 8'd0) begin
            n_err++;
            $display("FAIL sub0_res: got %0d want 0", if0.res_o);
        end
        n_cmp++;
        if (if0.zero_o !== 1'b1) begin
            n_err++;
            $display("FAIL sub0_zero: got %b want 1", if0.zero_o);
        end
        n_cmp++;
        if (if0.carry_o !== 1'b0) begin
            n_err++;
            $display("FAIL sub0_borrow: got %b want 0", if0.carry_o);
        end
        if0.req_i[0]    = 1'b0;
        if0.a_i[0 +: 8] = 8'd3;
        if0.b_i[0 +: 8] = 8'd4;
        tick();
        if0.req_i[0] = 1'b1;
        tick();
        n_cmp++;
        if (if0.gnt_o !== 4'b0001) begin
            n_err++;
            $display("FAIL sub1_gnt: got %b want 0001", if0.gnt_o);
        end
        tick();
        n_cmp++;
        if (if0.res_o !== 8'd255) begin
            n_err++;
            $display("FAIL sub1_res: got %0d want 255", if0.res_o);
        end
        n_cmp++;
        if (if0.carry_o !== 1'b1) begin
            n_err++;
            $display("FAIL sub1_borrow: got %b want 1", if0.carry_o);
        end
        n_cmp++;
        if (if0.zero_o !== 1'b0) begin
            n_err++;
            $display("FAIL sub1_zero: got %b want 0", if0.zero_o);
        end
        if0.req_i[0] = 1'b0;
        tick();
    endtask

    task automatic test_rr();
        logic [3:0] rel;
        logic [3:0] exp_g;
        logic [3:0] exp_a;
        logic [7:0] exp_r;
        int         k;
        for (int c = 0; c < 4; c++) begin
            if0.a_i[8*c +: 8] = 8'(16*c + 7);
            if0.b_i[8*c +: 8] = 8'(c + 1);
        end
        if0.mode_i = 4'hF;
        if0.req_i  = 4'hF;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        rel = '0;
        for (int n = 1; n <= 12; n++) begin
            tick();
            exp_g = 4'b0001 << ((n - 1) % 4);
            n_cmp++;
            if (if0.gnt_o !== exp_g) begin
                n_err++;
                $display("FAIL rr_gnt[%0d]: got %b want %b",
                         n, if0.gnt_o, exp_g);
            end
            exp_a = (n == 1) ? 4'b0000 : 4'b0001 << ((n - 2) % 4);
            n_cmp++;
            if (if0.ack_o !== exp_a) begin
                n_err++;
                $display("FAIL rr_ack[%0d]: got %b want %b",
                         n, if0.ack_o, exp_a);
            end
            if (n > 1) begin
                k     = (n - 2) % 4;
                exp_r = 8'(17*k + 8);
                n_cmp++;
                if (if0.res_o !== exp_r) begin
                    n_err++;
                    $display("FAIL rr_res[%0d]: got %0d want %0d",
                             n, if0.res_o, exp_r);
                end
            end
            // Clients drop req after their ack and raise it one cycle later.
            for (int c = 0; c < 4; c++) begin
                if (rel[c]) begin
                    if0.req_i[c] = 1'b1;
                    rel[c]       = 1'b0;
                end
                if (if0.ack_o[c]) begin
                    if0.req_i[c] = 1'b0;
                    rel[c]       = 1'b1;
                end
            end
        end
        if0.req_i = 4'h0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_fixed();
        if1.a_i[0 +: 8]  = 8'd10;
        if1.b_i[0 +: 8]  = 8'd3;
        if1.mode_i[0]    = 1'b0;
        if1.a_i[16 +: 8] = 8'hF0;
        if1.b_i[16 +: 8] = 8'h20;
        if1.mode_i[2]    = 1'b1;
        if1.req_i        = 4'b0101;
        n_cmp++;
        if (if1.busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL fp_busy0: got %b want 0", if1.busy_o);
        end
        tick();
        n_cmp++;
        if (if1.gnt_o !== 4'b0001) begin
            n_err++;
            $display("FAIL fp_gnt1: got %b want 0001", if1.gnt_o);
        end
        n_cmp++;
        if (if1.busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL fp_busy1: got %b want 1", if1.busy_o);
        end
        tick();
        n_cmp++;
        if (if1.gnt_o !== 4'b0100) begin
            n_err++;
            $display("FAIL fp_gnt2: got %b want 0100", if1.gnt_o);
        end
        n_cmp++;
        if (if1.ack_o !== 4'b0001) begin
            n_err++;
            $display("FAIL fp_ack0: got %b want 0001", if1.ack_o);
        end
        n_cmp++;
        if (if1.res_o !== 8'd7 || if1.carry_o !== 1'b0) begin
            n_err++;
            $display("FAIL fp_res0: got %0d/%b want 7/0",
                     if1.res_o, if1.carry_o);
        end
        n_cmp++;
        if (if1.busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL fp_busy2: got %b want 1", if1.busy_o);
        end
        if1.req_i[0] = 1'b0;
        tick();
        n_cmp++;
        if (if1.gnt_o !== 4'b0000) begin
            n_err++;
            $display("FAIL fp_gnt3: got %b want 0000", if1.gnt_o);
        end
        n_cmp++;
        if (if1.ack_o !== 4'b0100) begin
            n_err++;
            $display("FAIL fp_ack2: got %b want 0100", if1.ack_o);
        end
        n_cmp++;
        if (if1.res_o !== 8'h10 || if1.carry_o !== 1'b1) begin
            n_err++;
            $display("FAIL fp_res2: got %0d/%b want 16/1",
                     if1.res_o, if1.carry_o);
        end
        n_cmp++;
        if (if1.busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL fp_busy3: got %b want 1", if1.busy_o);
        end
        if1.req_i[2] = 1'b0;
        tick();
        n_cmp++;
        if (if1.busy_o !== 1'b0 || if1.ack_o !== 4'b0000) begin
            n_err++;
            $display("FAIL fp_done: got busy %b ack %b want 0/0000",
                     if1.busy_o, if1.ack_o);
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if0.req_i = 4'b0010;
        tick();
        n_cmp++;
        if (if0.gnt_o !== 4'b0010) begin
            n_err++;
            $display("FAIL rm_pre_gnt: got %b want 0010", if0.gnt_o);
        end
        tick();
        if0.req_i = 4'b0000;
        tick();
        if0.req_i = 4'b1010;
        tick();
        n_cmp++;
        if (if0.gnt_o !== 4'b1000) begin
            n_err++;
            $display("FAIL rm_gnt3: got %b want 1000", if0.gnt_o);
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if (if0.gnt_o !== 4'b0000 || if0.ack_o !== 4'b0000) begin
            n_err++;
            $display("FAIL rm_rst_hs: got gnt %b ack %b want 0000",
                     if0.gnt_o, if0.ack_o);
        end
        n_cmp++;
        if (if0.busy_o !== 1'b0 || if0.res_o !== 8'd0) begin
            n_err++;
            $display("FAIL rm_rst_out: got busy %b res %0d want 0/0",
                     if0.busy_o, if0.res_o);
        end
        n_cmp++;
        if (if0.carry_o !== 1'b0 || if0.zero_o !== 1'b0) begin
            n_err++;
            $display("FAIL rm_rst_flags: got %b%b want 00",
                     if0.carry_o, if0.zero_o);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (if0.gnt_o !== 4'b0010 || if0.ack_o !== 4'b0000) begin
            n_err++;
            $display("FAIL rm_post1: got gnt %b ack %b want 0010/0000",
                     if0.gnt_o, if0.ack_o);
        end
        tick();
        n_cmp++;
        if (if0.gnt_o !== 4'b1000 || if0.ack_o !== 4'b0010) begin
            n_err++;
            $display("FAIL rm_post2: got gnt %b ack %b want 1000/0010",
                     if0.gnt_o, if0.ack_o);
        end
        if0.req_i = 4'b0000;
        tick();
        tick();
    endtask

    initial begin
        if0.req_i  = '0;
        if0.mode_i = '0;
        if0.a_i    = '0;
        if0.b_i    = '0;
        if1.req_i  = '0;
        if1.mode_i = '0;
        if1.a_i    = '0;
        if1.b_i    = '0;
        test_reset();
        test_single_add();
        test_sub();
        test_rr();
        test_fixed();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
